// File: rtl/j2k_hdr_pkg.sv
// +--------------------------------------------------------------------------+
// | j2k_hdr_pkg: shared FSM states and field definitions for the header path |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package j2k_hdr_pkg;

  localparam int BIT_CNT_W  = 6;
  localparam int HDR_DATA_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  last;
    logic                  insert_zero;
    logic                  insert_ones;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [HDR_DATA_W-1:0] data;
  } hdr_field_t;

endpackage

`default_nettype wire

// File: rtl/hdr_rr_pick.sv
// +--------------------------------------------------------------------------+
// | hdr_rr_pick: combinational rotate-priority picker, one-hot grant         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hdr_rr_pick #(
  parameter int NUM_SRC = 3,
  parameter int PTR_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o
);

  logic             found;
  logic [PTR_W:0]   idx;

  // Scan NUM_SRC positions starting at ptr_i; first requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_SRC)) idx = idx - (PTR_W+1)'(NUM_SRC);
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hdr_src_arbiter.sv
// +--------------------------------------------------------------------------+
// | hdr_src_arbiter: packet-locked arbiter from header sources to assembler  |
// | Option macro: HDR_ARB_FIXED_PRIO_EN (lowest-index wins, no RR pointer)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hdr_src_arbiter
  import j2k_hdr_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int BIT_CNT_W  = j2k_hdr_pkg::BIT_CNT_W,
  parameter int HDR_DATA_W = j2k_hdr_pkg::HDR_DATA_W,
  parameter int PKT_BITS_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req_valid_i,
  input  logic [NUM_SRC-1:0]            req_last_i,
  input  logic [NUM_SRC-1:0]            req_insert_zero_i,
  input  logic [NUM_SRC-1:0]            req_insert_ones_i,
  input  logic [NUM_SRC*BIT_CNT_W-1:0]  req_bit_cnt_i,
  input  logic [NUM_SRC*HDR_DATA_W-1:0] req_data_i,
  output logic [NUM_SRC-1:0]            req_ready_o,
  output logic                          hdr_valid_o,
  output logic                          hdr_last_o,
  output logic                          hdr_insert_zero_o,
  output logic                          hdr_insert_ones_o,
  output logic [BIT_CNT_W-1:0]          hdr_bit_cnt_o,
  output logic [HDR_DATA_W-1:0]         hdr_data_o,
  input  logic                          hdr_ready_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic [PKT_BITS_W-1:0]         pkt_bits_o,
  output logic                          pkt_done_o,
  output logic                          err_o
);

  localparam int                   PTR_W   = $clog2(NUM_SRC);
  localparam logic [BIT_CNT_W-1:0] MAX_CNT = BIT_CNT_W'(HDR_DATA_W);

  arb_state_e              state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d, pick;
  logic [PTR_W-1:0]        rr_ptr_q;

  logic                    hdr_valid_q, hdr_last_q, hdr_iz_q, hdr_io_q;
  logic [BIT_CNT_W-1:0]    hdr_cnt_q;
  logic [HDR_DATA_W-1:0]   hdr_data_q;
  logic [PKT_BITS_W-1:0]   pkt_bits_q, pkt_bits_d;
  logic                    pkt_done_q, err_q, first_q;

  logic                    sel_last, sel_iz, sel_io, cnt_over, accept;
  logic [BIT_CNT_W-1:0]    sel_cnt, clamp_cnt;
  logic [HDR_DATA_W-1:0]   sel_data;
  logic [PKT_BITS_W:0]     pkt_sum;

  assign req_ready_o = grant_q & {NUM_SRC{(state_q == ST_LOCK) & (~hdr_valid_q | hdr_ready_i)}};
  assign accept      = |(req_valid_i & req_ready_o);

  // Owner's field, selected by the one-hot grant.
  always_comb begin
    sel_last = 1'b0;
    sel_iz   = 1'b0;
    sel_io   = 1'b0;
    sel_cnt  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) begin
        sel_last = sel_last | req_last_i[k];
        sel_iz   = sel_iz   | req_insert_zero_i[k];
        sel_io   = sel_io   | req_insert_ones_i[k];
        sel_cnt  = sel_cnt  | req_bit_cnt_i[k*BIT_CNT_W +: BIT_CNT_W];
        sel_data = sel_data | req_data_i[k*HDR_DATA_W +: HDR_DATA_W];
      end
    end
  end

  assign cnt_over   = 32'(sel_cnt) > 32'(HDR_DATA_W);
  assign clamp_cnt  = cnt_over ? MAX_CNT : sel_cnt;
  assign pkt_sum    = {1'b0, pkt_bits_q} + (PKT_BITS_W+1)'(clamp_cnt);
  assign pkt_bits_d = first_q          ? PKT_BITS_W'(clamp_cnt) :
                      pkt_sum[PKT_BITS_W] ? '1 : pkt_sum[PKT_BITS_W-1:0];

`ifdef HDR_ARB_FIXED_PRIO_EN
  assign rr_ptr_q = '0;
`else
  logic [PTR_W-1:0] rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && sel_last) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (grant_q[k]) rr_ptr_d = (k == NUM_SRC-1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  hdr_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: if (|req_valid_i) begin
        state_d = ST_LOCK;
        grant_d = pick;
      end
      ST_LOCK: if (accept && sel_last) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      hdr_valid_q <= 1'b0;
      hdr_last_q  <= 1'b0;
      hdr_iz_q    <= 1'b0;
      hdr_io_q    <= 1'b0;
      hdr_cnt_q   <= '0;
      hdr_data_q  <= '0;
      pkt_bits_q  <= '0;
      pkt_done_q  <= 1'b0;
      err_q       <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pkt_done_q <= accept & sel_last;
      if (accept) begin
        hdr_valid_q <= 1'b1;
        hdr_last_q  <= sel_last;
        hdr_iz_q    <= sel_iz;
        hdr_io_q    <= sel_io;
        hdr_cnt_q   <= clamp_cnt;
        hdr_data_q  <= sel_data;
        pkt_bits_q  <= pkt_bits_d;
        first_q     <= sel_last;
        if (cnt_over || (sel_iz && sel_io)) err_q <= 1'b1;
      end else if (hdr_ready_i) begin
        hdr_valid_q <= 1'b0;
      end
    end
  end

  assign grant_o           = grant_q;
  assign hdr_valid_o       = hdr_valid_q;
  assign hdr_last_o        = hdr_last_q;
  assign hdr_insert_zero_o = hdr_iz_q;
  assign hdr_insert_ones_o = hdr_io_q;
  assign hdr_bit_cnt_o     = hdr_cnt_q;
  assign hdr_data_o        = hdr_data_q;
  assign pkt_bits_o        = pkt_bits_q;
  assign pkt_done_o        = pkt_done_q;
  assign err_o             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hdr_src_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_hdr_src_arbiter: directed self-checking bench for hdr_src_arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hdr_src_arbiter;

  localparam int NS = 3;
  localparam int CW = 6;
  localparam int DW = 32;
  localparam int PW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    req_valid, req_last, req_iz, req_io;
  logic [NS*CW-1:0] req_cnt;
  logic [NS*DW-1:0] req_data;
  logic [NS-1:0]    req_ready;
  logic             hdr_valid, hdr_last, hdr_iz, hdr_io, hdr_ready;
  logic [CW-1:0]    hdr_cnt;
  logic [DW-1:0]    hdr_data;
  logic [NS-1:0]    grant;
  logic [PW-1:0]    pkt_bits;
  logic             pkt_done, err;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hdr_src_arbiter #(
    .NUM_SRC(NS), .BIT_CNT_W(CW), .HDR_DATA_W(DW), .PKT_BITS_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_last_i(req_last),
    .req_insert_zero_i(req_iz), .req_insert_ones_i(req_io),
    .req_bit_cnt_i(req_cnt), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .hdr_valid_o(hdr_valid), .hdr_last_o(hdr_last),
    .hdr_insert_zero_o(hdr_iz), .hdr_insert_ones_o(hdr_io),
    .hdr_bit_cnt_o(hdr_cnt), .hdr_data_o(hdr_data),
    .hdr_ready_i(hdr_ready),
    .grant_o(grant), .pkt_bits_o(pkt_bits), .pkt_done_o(pkt_done), .err_o(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    req_valid = '0; req_last = '0; req_iz = '0; req_io = '0;
    req_cnt   = '0; req_data = '0;
  endtask

  task automatic set_src(input int k, input logic v, input logic l,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_last[k]  = l;
    req_cnt[k*CW +: CW] = c;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_all();
    hdr_ready = 1'b1;
    do_reset();
    nchk++; if (hdr_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got=%b exp=0", hdr_valid); end
    nchk++; if (grant !== 3'b000) begin nfail++; $display("FAIL rst_grant got=%b exp=000", grant); end
    nchk++; if (pkt_bits !== 16'd0) begin nfail++; $display("FAIL rst_pkt_bits got=%0d exp=0", pkt_bits); end
    nchk++; if (pkt_done !== 1'b0) begin nfail++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
    nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL rst_err got=%b exp=0", err); end
    nchk++; if (req_ready !== 3'b000) begin nfail++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    nchk++; if (hdr_data !== 32'd0) begin nfail++; $display("FAIL rst_data got=%h exp=0", hdr_data); end
  endtask

  task automatic test_single_src();
    set_src(1, 1'b1, 1'b0, 6'd8, 32'hA1);
    step();
    nchk++; if (grant !== 3'b010) begin nfail++; $display("FAIL t1_grant got=%b exp=010", grant); end
    nchk++; if (req_ready !== 3'b010) begin nfail++; $display("FAIL t1_ready got=%b exp=010", req_ready); end
    nchk++; if (hdr_valid !== 1'b0) begin nfail++; $display("FAIL t1_bubble got=%b exp=0", hdr_valid); end
    step();
    nchk++; if (hdr_valid !== 1'b1 || hdr_data !== 32'hA1 || hdr_cnt !== 6'd8 || hdr_last !== 1'b0)
      begin nfail++; $display("FAIL t1_f1 got v=%b d=%h c=%0d l=%b exp v=1 d=a1 c=8 l=0", hdr_valid, hdr_data, hdr_cnt, hdr_last); end
    nchk++; if (pkt_bits !== 16'd8) begin nfail++; $display("FAIL t1_bits1 got=%0d exp=8", pkt_bits); end
    set_src(1, 1'b1, 1'b0, 6'd16, 32'hA2);
    step();
    nchk++; if (hdr_valid !== 1'b1 || hdr_data !== 32'hA2) begin nfail++; $display("FAIL t1_f2 got v=%b d=%h exp v=1 d=a2", hdr_valid, hdr_data); end
    nchk++; if (pkt_bits !== 16'd24) begin nfail++; $display("FAIL t1_bits2 got=%0d exp=24", pkt_bits); end
    set_src(1, 1'b1, 1'b1, 6'd4, 32'hA3);
    step();
    clr_all();
    nchk++; if (hdr_valid !== 1'b1 || hdr_data !== 32'hA3 || hdr_last !== 1'b1)
      begin nfail++; $display("FAIL t1_f3 got v=%b d=%h l=%b exp v=1 d=a3 l=1", hdr_valid, hdr_data, hdr_last); end
    nchk++; if (pkt_bits !== 16'd28) begin nfail++; $display("FAIL t1_bits3 got=%0d exp=28", pkt_bits); end
    nchk++; if (pkt_done !== 1'b1) begin nfail++; $display("FAIL t1_done got=%b exp=1", pkt_done); end
    nchk++; if (grant !== 3'b000) begin nfail++; $display("FAIL t1_release got=%b exp=000", grant); end
    step();
    nchk++; if (hdr_valid !== 1'b0 || pkt_done !== 1'b0) begin nfail++; $display("FAIL t1_end got v=%b done=%b exp 0 0", hdr_valid, pkt_done); end
    nchk++; if (pkt_bits !== 16'd28) begin nfail++; $display("FAIL t1_hold got=%0d exp=28", pkt_bits); end
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] exp_g;
    logic [DW-1:0] exp_d;
    logic [PW-1:0] exp_b;
`ifdef HDR_ARB_FIXED_PRIO_EN
    exp_g = 3'b001; exp_d = 32'hB0; exp_b = 16'd1;
`else
    exp_g = 3'b100; exp_d = 32'hB2; exp_b = 16'd2;
`endif
    clr_all();
    do_reset();
    set_src(0, 1'b1, 1'b1, 6'd1, 32'hB0);
    set_src(2, 1'b1, 1'b1, 6'd2, 32'hB2);
    step();
    nchk++; if (grant !== 3'b001) begin nfail++; $display("FAIL t2_first got=%b exp=001", grant); end
    step();
    nchk++; if (hdr_data !== 32'hB0 || pkt_done !== 1'b1) begin nfail++; $display("FAIL t2_pkt0 got d=%h done=%b exp d=b0 done=1", hdr_data, pkt_done); end
    step();
    nchk++; if (grant !== exp_g) begin nfail++; $display("FAIL t2_second got=%b exp=%b", grant, exp_g); end
    nchk++; if (hdr_valid !== 1'b0) begin nfail++; $display("FAIL t2_gap got=%b exp=0", hdr_valid); end
    step();
    clr_all();
    nchk++; if (hdr_valid !== 1'b1 || hdr_data !== exp_d) begin nfail++; $display("FAIL t2_pkt1 got v=%b d=%h exp v=1 d=%h", hdr_valid, hdr_data, exp_d); end
    nchk++; if (pkt_bits !== exp_b) begin nfail++; $display("FAIL t2_bits got=%0d exp=%0d", pkt_bits, exp_b); end
    step();
  endtask

  task automatic test_backpressure();
    clr_all();
    do_reset();
    set_src(1, 1'b1, 1'b0, 6'd1, 32'hC0);
    step();
    step();
    hdr_ready = 1'b0;
    set_src(1, 1'b1, 1'b0, 6'd2, 32'hC1);
    #1;
    nchk++; if (req_ready !== 3'b000) begin nfail++; $display("FAIL t3_stall_ready got=%b exp=000", req_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      nchk++; if (hdr_valid !== 1'b1 || hdr_data !== 32'hC0 || hdr_cnt !== 6'd1)
        begin nfail++; $display("FAIL t3_hold%0d got v=%b d=%h c=%0d exp v=1 d=c0 c=1", i, hdr_valid, hdr_data, hdr_cnt); end
      nchk++; if (req_ready !== 3'b000) begin nfail++; $display("FAIL t3_ready%0d got=%b exp=000", i, req_ready); end
    end
    hdr_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 3'b010) begin nfail++; $display("FAIL t3_resume got=%b exp=010", req_ready); end
    step();
    nchk++; if (hdr_valid !== 1'b1 || hdr_data !== 32'hC1) begin nfail++; $display("FAIL t3_c1 got v=%b d=%h exp v=1 d=c1", hdr_valid, hdr_data); end
    nchk++; if (pkt_bits !== 16'd3) begin nfail++; $display("FAIL t3_bits1 got=%0d exp=3", pkt_bits); end
    set_src(1, 1'b1, 1'b1, 6'd3, 32'hC2);
    step();
    clr_all();
    nchk++; if (hdr_data !== 32'hC2 || hdr_last !== 1'b1 || pkt_bits !== 16'd6)
      begin nfail++; $display("FAIL t3_c2 got d=%h l=%b bits=%0d exp d=c2 l=1 bits=6", hdr_data, hdr_last, pkt_bits); end
    step();
    nchk++; if (hdr_valid !== 1'b0) begin nfail++; $display("FAIL t3_dup got=%b exp=0", hdr_valid); end
  endtask

  task automatic test_lock_hold();
    clr_all();
    do_reset();
    set_src(2, 1'b1, 1'b0, 6'd1, 32'hD0);
    step();
    set_src(0, 1'b1, 1'b1, 6'd5, 32'hE0);
    step();
    nchk++; if (hdr_data !== 32'hD0) begin nfail++; $display("FAIL t4_d0 got=%h exp=d0", hdr_data); end
    set_src(2, 1'b0, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++; if (grant !== 3'b100 || req_ready !== 3'b100)
        begin nfail++; $display("FAIL t4_lock%0d got g=%b r=%b exp g=100 r=100", i, grant, req_ready); end
    end
    nchk++; if (hdr_valid !== 1'b0) begin nfail++; $display("FAIL t4_idle got=%b exp=0", hdr_valid); end
    set_src(2, 1'b1, 1'b1, 6'd2, 32'hD1);
    step();
    set_src(2, 1'b0, 1'b0, 6'd0, 32'h0);
    nchk++; if (hdr_data !== 32'hD1 || grant !== 3'b000 || pkt_bits !== 16'd3)
      begin nfail++; $display("FAIL t4_d1 got d=%h g=%b bits=%0d exp d=d1 g=000 bits=3", hdr_data, grant, pkt_bits); end
    step();
    nchk++; if (grant !== 3'b001) begin nfail++; $display("FAIL t4_src0 got=%b exp=001", grant); end
    step();
    clr_all();
    nchk++; if (hdr_data !== 32'hE0 || pkt_bits !== 16'd5) begin nfail++; $display("FAIL t4_e0 got d=%h bits=%0d exp d=e0 bits=5", hdr_data, pkt_bits); end
    step();
  endtask

  task automatic test_saturate();
    clr_all();
    do_reset();
    set_src(0, 1'b1, 1'b0, 6'd32, 32'h5A);
    step();
    for (int i = 0; i < 2100; i++) step();
    nchk++; if (pkt_bits !== 16'hFFFF) begin nfail++; $display("FAIL t_sat got=%h exp=ffff", pkt_bits); end
    set_src(0, 1'b1, 1'b1, 6'd0, 32'h5B);
    step();
    clr_all();
    nchk++; if (pkt_bits !== 16'hFFFF || pkt_done !== 1'b1) begin nfail++; $display("FAIL t_sat_last got bits=%h done=%b exp ffff 1", pkt_bits, pkt_done); end
    step();
    nchk++; if (pkt_bits !== 16'hFFFF) begin nfail++; $display("FAIL t_sat_hold got=%h exp=ffff", pkt_bits); end
    set_src(0, 1'b1, 1'b1, 6'd7, 32'h5C);
    step();
    step();
    clr_all();
    nchk++; if (pkt_bits !== 16'd7) begin nfail++; $display("FAIL t_new_pkt got=%0d exp=7", pkt_bits); end
    step();
  endtask

  task automatic test_clamp_err();
    clr_all();
    do_reset();
    set_src(0, 1'b1, 1'b1, 6'd40, 32'hF0);
    step();
    step();
    clr_all();
    nchk++; if (hdr_cnt !== 6'd32) begin nfail++; $display("FAIL t5_clamp got=%0d exp=32", hdr_cnt); end
    nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL t5_err got=%b exp=1", err); end
    nchk++; if (pkt_bits !== 16'd32) begin nfail++; $display("FAIL t5_bits got=%0d exp=32", pkt_bits); end
    set_src(1, 1'b1, 1'b1, 6'd3, 32'hF1);
    step();
    step();
    clr_all();
    step();
    nchk++; if (err !== 1'b1 || hdr_cnt !== 6'd3) begin nfail++; $display("FAIL t5_sticky got err=%b c=%0d exp err=1 c=3", err, hdr_cnt); end
  endtask

  task automatic test_insert();
    clr_all();
    do_reset();
    nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL ins_err_clr got=%b exp=0", err); end
    set_src(0, 1'b1, 1'b1, 6'd0, 32'h0);
    req_iz[0] = 1'b1;
    step();
    step();
    clr_all();
    nchk++; if (hdr_iz !== 1'b1 || hdr_io !== 1'b0 || err !== 1'b0)
      begin nfail++; $display("FAIL ins_zero got iz=%b io=%b err=%b exp 1 0 0", hdr_iz, hdr_io, err); end
    set_src(0, 1'b1, 1'b1, 6'd0, 32'h0);
    req_iz[0] = 1'b1;
    req_io[0] = 1'b1;
    step();
    step();
    clr_all();
    nchk++; if (hdr_iz !== 1'b1 || hdr_io !== 1'b1 || err !== 1'b1)
      begin nfail++; $display("FAIL ins_both got iz=%b io=%b err=%b exp 1 1 1", hdr_iz, hdr_io, err); end
    step();
  endtask

  task automatic test_reset_mid();
    clr_all();
    set_src(1, 1'b1, 1'b0, 6'd9, 32'h66);
    step();
    step();
    nchk++; if (hdr_valid !== 1'b1 || grant !== 3'b010) begin nfail++; $display("FAIL t6_pre got v=%b g=%b exp 1 010", hdr_valid, grant); end
    rst = 1'b1;
    step();
    nchk++; if (hdr_valid !== 1'b0 || grant !== 3'b000 || hdr_data !== 32'd0 || hdr_cnt !== 6'd0 ||
                pkt_bits !== 16'd0 || err !== 1'b0 || pkt_done !== 1'b0 || req_ready !== 3'b000)
      begin nfail++; $display("FAIL t6_cleared got v=%b g=%b d=%h c=%0d bits=%0d err=%b done=%b r=%b exp all 0",
                              hdr_valid, grant, hdr_data, hdr_cnt, pkt_bits, err, pkt_done, req_ready); end
    rst = 1'b0;
    set_src(0, 1'b1, 1'b1, 6'd1, 32'h77);
    step();
    nchk++; if (grant !== 3'b001) begin nfail++; $display("FAIL t6_ptr got=%b exp=001", grant); end
    step();
    clr_all();
    nchk++; if (hdr_data !== 32'h77 || pkt_bits !== 16'd1) begin nfail++; $display("FAIL t6_after got d=%h bits=%0d exp 77 1", hdr_data, pkt_bits); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    hdr_ready = 1'b1;
    clr_all();
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_lock_hold();
    test_saturate();
    test_clamp_err();
    test_insert();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
